fwd_hazard_unit: RTL and testbench

- Generates the `forwarda`/`forwardb` select codes that drive the EX-stage ALU operand muxes: 00 = ID/EX register data, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- Keeps its own shadow copy of the EX/MEM and MEM/WB destination fields, advanced in lockstep with the pipeline.
- Detects load-use hazards on the instruction currently in EX and raises a one-cycle stall.
- Counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit.sv | 87 ++++++++
 tb/tb_fwd_hazard_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard detection.
// Tracks the EX/MEM and MEM/WB destination fields and counts stall cycles.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_en,
  input  logic             ex_flush,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_uses_rs,
  input  logic             idex_uses_rt,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic             idex_regwen,
  input  logic             idex_memread,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             load_stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [REG_W-1:0] em_wsel;
  logic             em_wen;
  logic             em_load;
  logic [REG_W-1:0] mw_wsel;
  logic             mw_wen;

  logic em_hit_rs, em_hit_rt, mw_hit_rs, mw_hit_rt;

  function automatic logic reg_hit(input logic             wen,
                                   input logic [REG_W-1:0] wsel,
                                   input logic [REG_W-1:0] r);
    return wen && (wsel == r) && (r != '0);
  endfunction

  // A matching load in EX/MEM has no data yet, so it falls through to MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic uses,
                                         input logic em_h,
                                         input logic em_ld,
                                         input logic mw_h);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses) begin
      if (em_h && !em_ld) sel = 2'b01;
      else if (mw_h)      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    em_hit_rs  = reg_hit(em_wen, em_wsel, idex_rs);
    em_hit_rt  = reg_hit(em_wen, em_wsel, idex_rt);
    mw_hit_rs  = reg_hit(mw_wen, mw_wsel, idex_rs);
    mw_hit_rt  = reg_hit(mw_wen, mw_wsel, idex_rt);
    load_stall = em_load && ((idex_uses_rs && em_hit_rs) || (idex_uses_rt && em_hit_rt));
    forwarda   = fwd_sel(idex_uses_rs, em_hit_rs, em_load, mw_hit_rs);
    forwardb   = fwd_sel(idex_uses_rt, em_hit_rt, em_load, mw_hit_rt);
  end

  // Shadow pipeline advance: EX/MEM -> MEM/WB, ID/EX (or bubble) -> EX/MEM
  always_ff @(posedge CLK) begin
    if (RST) begin
      em_wsel     <= '0;
      em_wen      <= 1'b0;
      em_load     <= 1'b0;
      mw_wsel     <= '0;
      mw_wen      <= 1'b0;
      stall_count <= '0;
    end else if (ex_en) begin
      mw_wsel <= em_wsel;
      mw_wen  <= em_wen;
      if (load_stall || ex_flush) begin
        em_wsel <= '0;
        em_wen  <= 1'b0;
        em_load <= 1'b0;
      end else begin
        em_wsel <= idex_wsel;
        em_wen  <= idex_regwen;
        em_load <= idex_memread;
      end
      if (load_stall) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding paths, load-use stall, hold, flush, reset.
module tb_fwd_hazard_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ex_en, ex_flush;
  logic [REG_W-1:0] idex_rs, idex_rt, idex_wsel;
  logic             idex_uses_rs, idex_uses_rt, idex_regwen, idex_memread;
  logic [1:0]       forwarda, forwardb;
  logic             load_stall;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ex_en(ex_en), .ex_flush(ex_flush),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_uses_rs(idex_uses_rs), .idex_uses_rt(idex_uses_rt),
    .idex_wsel(idex_wsel), .idex_regwen(idex_regwen), .idex_memread(idex_memread),
    .forwarda(forwarda), .forwardb(forwardb),
    .load_stall(load_stall), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    idex_rs = '0; idex_rt = '0; idex_wsel = '0;
    idex_uses_rs = 0; idex_uses_rt = 0; idex_regwen = 0; idex_memread = 0;
    ex_flush = 0;
  endtask

  task automatic producer(input logic [REG_W-1:0] w, input logic ld);
    idle_in();
    idex_wsel = w; idex_regwen = 1; idex_memread = ld;
  endtask

  task automatic consumer(input logic [REG_W-1:0] rs, input logic urs,
                          input logic [REG_W-1:0] rt, input logic urt);
    idle_in();
    idex_rs = rs; idex_uses_rs = urs; idex_rt = rt; idex_uses_rt = urt;
  endtask

  task automatic drain();
    idle_in();
    ex_en = 1;
    step(); step();
  endtask

  initial begin
    RST = 1; ex_en = 0; idle_in();
    step(); step();
    RST = 0; #1;
    check("rst_fa", {30'd0, forwarda}, 32'd0);
    check("rst_fb", {30'd0, forwardb}, 32'd0);
    check("rst_ls", {31'd0, load_stall}, 32'd0);
    check("rst_cnt", stall_count, 32'd0);

    // back-to-back ALU ops
    ex_en = 1;
    producer(8, 0); step();
    consumer(8, 1, 0, 0); #1;
    check("alu_d1_fa", {30'd0, forwarda}, 32'd1);
    step();
    check("alu_d2_fa", {30'd0, forwarda}, 32'd2);
    step();
    check("alu_d3_fa", {30'd0, forwarda}, 32'd0);

    // load-use on rt
    producer(9, 1); step();
    consumer(0, 0, 9, 1); #1;
    check("lu_ls", {31'd0, load_stall}, 32'd1);
    check("lu_fb", {30'd0, forwardb}, 32'd0);
    step();
    check("lu_ls_after", {31'd0, load_stall}, 32'd0);
    check("lu_fb_after", {30'd0, forwardb}, 32'd2);
    check("lu_cnt", stall_count, 32'd1);
    drain();

    // double producer: EX/MEM wins over MEM/WB
    producer(5, 0); step(); step();
    consumer(5, 1, 5, 1); #1;
    check("dbl_fa", {30'd0, forwarda}, 32'd1);
    check("dbl_fb", {30'd0, forwardb}, 32'd1);
    drain();

    // register 0 never forwarded
    producer(0, 0); step();
    consumer(0, 1, 0, 1); #1;
    check("r0_fa", {30'd0, forwarda}, 32'd0);
    check("r0_fb", {30'd0, forwardb}, 32'd0);
    drain();

    // unused operand matching a load
    producer(4, 1); step();
    consumer(0, 0, 4, 0); #1;
    check("unused_fb", {30'd0, forwardb}, 32'd0);
    check("unused_ls", {31'd0, load_stall}, 32'd0);
    drain();

    // hold with ex_en=0 during a pending load-use
    producer(9, 1); step();
    consumer(0, 0, 9, 1); ex_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ls", {31'd0, load_stall}, 32'd1);
      check("hold_cnt", stall_count, 32'd1);
    end
    ex_en = 1; step();
    check("hold_release_cnt", stall_count, 32'd2);
    check("hold_release_fb", {30'd0, forwardb}, 32'd2);
    drain();

    // flushed producer is not forwarded
    producer(7, 0); ex_flush = 1; step();
    consumer(7, 1, 0, 0); #1;
    check("flush_fa", {30'd0, forwarda}, 32'd0);
    step();
    check("flush_fa_mw", {30'd0, forwarda}, 32'd0);
    drain();

    // simultaneous flush and stall
    producer(3, 1); step();
    consumer(3, 1, 0, 0); ex_flush = 1; #1;
    check("fs_ls", {31'd0, load_stall}, 32'd1);
    step();
    check("fs_cnt", stall_count, 32'd3);
    check("fs_fa", {30'd0, forwarda}, 32'd2);
    check("fs_ls_after", {31'd0, load_stall}, 32'd0);
    drain();

    // reset mid-stall
    producer(6, 1); step();
    consumer(6, 1, 0, 0); #1;
    check("rs_ls_pre", {31'd0, load_stall}, 32'd1);
    RST = 1; step();
    check("rs_ls", {31'd0, load_stall}, 32'd0);
    check("rs_cnt", stall_count, 32'd0);
    check("rs_fa", {30'd0, forwarda}, 32'd0);
    RST = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
